// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State enum, multi-cycle bounds, timer and stats counter widths.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } hz_state_t;

  localparam int MULTI_CYCLES_MIN = 2;
  localparam int MULTI_CYCLES_MAX = 16;
  localparam int CNT_W            = 4;
  localparam int STAT_W           = 16;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard bundle between the pipeline (master) and hazard_ctrl (slave).
// Master drives ID/EX hazard inputs; slave returns stall/flush/hold.
interface hazard_ctrl_if;

  logic [3:0] IDRs1;
  logic [3:0] IDRs2;
  logic       IDRs1Used;
  logic       IDRs2Used;
  logic [3:0] EXRd;
  logic       EXMemRead;
  logic       EXMultiStart;
  logic       BranchTaken;
  logic       StopPC;
  logic       IDEXFlush;
  logic       IFIDFlush;
  logic       EXHold;

  modport master (
    output IDRs1, IDRs2, IDRs1Used, IDRs2Used,
    output EXRd, EXMemRead, EXMultiStart, BranchTaken,
    input  StopPC, IDEXFlush, IFIDFlush, EXHold
  );

  modport slave (
    input  IDRs1, IDRs2, IDRs1Used, IDRs2Used,
    input  EXRd, EXMemRead, EXMultiStart, BranchTaken,
    output StopPC, IDEXFlush, IFIDFlush, EXHold
  );

endinterface

// File: rtl/multi_cycle_timer.sv
// Down-counter sequencing the remaining EX cycles of a mul/div op.
// Ports: clk, rst, load, load_val, dec in; done out (cnt == 0).
module multi_cycle_timer
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, branch flush, mul/div EX hold.
// Ports: clk, rst, hz (slave bundle); HAZARD_CTRL_STATS_EN adds
// StallCount/FlushCount saturating event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULTI_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_if.slave      hz
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] StallCount,
  output logic [STAT_W-1:0] FlushCount
`endif
);

  // RUN covers the start cycle and the last cycle, so MULTI
  // lasts MULTI_CYCLES-2 cycles: cnt runs from MULTI_CYCLES-3 to 0.
  localparam int LOADV =
    (MULTI_CYCLES > 2) ? MULTI_CYCLES - 3 : 0;

  if (MULTI_CYCLES < MULTI_CYCLES_MIN ||
      MULTI_CYCLES > MULTI_CYCLES_MAX) begin : g_bad_cycles
    $error("hazard_ctrl: MULTI_CYCLES out of range");
  end

  hz_state_t state, state_n;
  logic      t_load, t_dec, t_done;
  logic      load_use;
  logic      stop, idex_fl, ifid_fl, hold;

  multi_cycle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (CNT_W'(LOADV)),
    .dec      (t_dec),
    .done     (t_done)
  );

  assign load_use = hz.EXMemRead &&
    ((hz.IDRs1Used && hz.IDRs1 == hz.EXRd) ||
     (hz.IDRs2Used && hz.IDRs2 == hz.EXRd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RUN;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    stop    = 1'b0;
    idex_fl = 1'b0;
    ifid_fl = 1'b0;
    hold    = 1'b0;
    unique case (state)
      RUN: begin
        if (hz.BranchTaken) begin
          ifid_fl = 1'b1;
          idex_fl = 1'b1;
        end else if (hz.EXMultiStart) begin
          stop = 1'b1;
          hold = 1'b1;
          if (MULTI_CYCLES > 2) begin
            t_load  = 1'b1;
            state_n = MULTI;
          end
        end else if (load_use) begin
          stop    = 1'b1;
          idex_fl = 1'b1;
        end
      end
      MULTI: begin
        stop = 1'b1;
        hold = 1'b1;
        if (t_done)
          state_n = RUN;
        else
          t_dec = 1'b1;
      end
      default: state_n = RUN;
    endcase
    // Outputs fall with rst itself, not at the next edge.
    if (rst) begin
      stop    = 1'b0;
      idex_fl = 1'b0;
      ifid_fl = 1'b0;
      hold    = 1'b0;
    end
  end

  assign hz.StopPC    = stop;
  assign hz.IDEXFlush = idex_fl;
  assign hz.IFIDFlush = ifid_fl;
  assign hz.EXHold    = hold;

`ifdef HAZARD_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stop && StallCount != '1)
        StallCount <= StallCount + 1'b1;
      if (ifid_fl && FlushCount != '1)
        FlushCount <= FlushCount + 1'b1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage 16-bit datapath. Each cycle it decides whether the IF/ID and ID/EX registers advance, hold or take a bubble. It drives the `StopPC` and `flush` controls of the ID/EX register, a flush for IF/ID, and a hold for the EX stage. It covers three cases: load-use stalls, taken-branch flushes, and multi-cycle EX operations (mul/div), the last sequenced by an internal state machine and counter.

## Interface
- `MULTI_CYCLES`, default 4: total cycles a multi-cycle op occupies EX; legal range 2..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `IDRs1`, `IDRs2`  in  4 each  source register fields of the instruction in IF/ID.
- `IDRs1Used`, `IDRs2Used`  in  1 each  the instruction in IF/ID actually reads that source.
- `EXRd`  in  4  destination register of the instruction in ID/EX.
- `EXMemRead`  in  1  the instruction in ID/EX is a load.
- `EXMultiStart`  in  1  a multi-cycle op is in its first EX cycle.
- `BranchTaken`  in  1  branch resolved taken in EX this cycle.
- `StopPC`  out  1  hold PC and IF/ID; goes to ID/EX `StopPC`.
- `IDEXFlush`  out  1  insert a bubble into ID/EX; goes to ID/EX `flush`.
- `IFIDFlush`  out  1  clear IF/ID.
- `EXHold`  out  1  hold ID/EX and EX-stage operands; EX/MEM receives a bubble.

## Operation
- States: `RUN`, `MULTI`. Counter `cnt` is 4 bits.
- Outputs are combinational from state and inputs. State and `cnt` are registered.
- Priority in `RUN`, highest first:
  1. Branch: `BranchTaken` asserts `IFIDFlush=1` and `IDEXFlush=1`. Stay in `RUN`. If `EXMultiStart` is high in the same cycle, it is ignored.
  2. Multi-cycle op: `EXMultiStart` asserts `StopPC=1` and `EXHold=1`.
     - `MULTI_CYCLES==2`: stay in `RUN`.
     - Otherwise: load `cnt = MULTI_CYCLES-3` and go to `MULTI`.
  3. Load-use: `EXMemRead` and either (`IDRs1Used` and `IDRs1==EXRd`) or (`IDRs2Used` and `IDRs2==EXRd`). This asserts `StopPC=1` and `IDEXFlush=1` for one cycle. Stay in `RUN`; the hazard clears once the load reaches MEM.
  4. No hazard: all outputs 0.
- `MULTI`:
  - `StopPC=1`, `EXHold=1`, `IDEXFlush=0`, `IFIDFlush=0`.
  - `BranchTaken`, `EXMultiStart` and load-use are ignored.
  - If `cnt==0`, go to `RUN`; else `cnt` decrements.
- Net effect: `EXHold` is asserted for exactly `MULTI_CYCLES-1` consecutive cycles, starting in the `EXMultiStart` cycle. The op leaves EX at the end of cycle `MULTI_CYCLES`.
- A load-use hazard that exists on exit from `MULTI` is evaluated in the first `RUN` cycle.

## Timing
- Reset: all outputs 0, state `RUN`, `cnt=0`. Reset asserted mid-`MULTI` aborts the sequence immediately. Outputs drop asynchronously.
- Zero-cycle decision latency: outputs respond in the same cycle as their inputs. Transitions occur on the rising edge of `clk`.
- Load-use costs exactly 1 bubble. A taken branch costs 2 squashed instructions. A multi-cycle op costs `MULTI_CYCLES-1` stall cycles.
- `IDEXFlush` and `EXHold` are never high in the same cycle. `IFIDFlush` is never high in `MULTI`.

## Configuration
- `HAZARD_CTRL_STATS_EN` defined adds two outputs, `StallCount` and `FlushCount`, each 16 bits, saturating at 0xFFFF and cleared by `rst`.
  - `StallCount` increments on every cycle with `StopPC=1`.
  - `FlushCount` increments on every cycle with `IFIDFlush=1`.
- Macro undefined: the ports and counters are absent, and control behaviour is identical.

## Structure
- Package `hazard_pkg` contains:
  - the state enum (`RUN`, `MULTI`);
  - constants `MULTI_CYCLES_MIN=2`, `MULTI_CYCLES_MAX=16` and the counter width of 4;
  - the stats counter width of 16.
- One sub-module, `multi_cycle_timer`, holds `cnt`. Its interface is load, load value, decrement, and a `done` flag for `cnt==0`. The top module holds the FSM and hazard compare.

## Test plan
- Load-use: `EXMemRead=1`, `EXRd=3`, `IDRs1=3`, `IDRs1Used=1` for one cycle -> `StopPC=1`, `IDEXFlush=1` that cycle only. The next cycle, with `EXMemRead=0`, all outputs are 0.
- False hazard: `EXRd=3`, `IDRs2=3`, `IDRs2Used=0`, `IDRs1=5` -> no stall.
- Multi-cycle with `MULTI_CYCLES=4`: pulse `EXMultiStart` at cycle t -> `EXHold=1` and `StopPC=1` for cycles t..t+2, 0 at t+3. A load-use presented during t+1 is ignored.
- Branch priority: `BranchTaken=1` and `EXMultiStart=1` together -> `IFIDFlush=1`, `IDEXFlush=1`, `EXHold=0`, state stays `RUN`.
- Reset mid-`MULTI`: assert `rst` at t+1 of a `MULTI_CYCLES=8` sequence -> all outputs 0 immediately. After release, no residual hold.
- Stats build: 3 load-use stalls plus 1 branch -> `StallCount=3`, `FlushCount=1`. Forcing 0xFFFF events leaves `StallCount` saturated at 0xFFFF.
